adj_control: RTL and testbench
==============================

# adj_control

Parametrised front-panel control block for the video pipeline. It turns DE1 pushbuttons and slide switches into per-channel adjustment levels, such as brightness and contrast, with saturating up/down steps and auto-repeat while a key is held. It also generates the once-per-frame `frame_en` strobe. Downstream pixel stages read `lvl`, which changes only on a frame boundary, so an adjustment never tears mid-frame.

## Interface
Parameters:
- `NCH`, 4: number of adjustable channels (1..8); channel i is selected by `SW[i]`.
- `LW`, 8: level width in bits.
- `STEP`, 4: increment/decrement per step event (1..2^LW-1).
- `LVL_RST`, 128: reset/default level of every channel.
- `ROW_MAX`, 480: frame-boundary row.
- `COL_MAX`, 640: frame-boundary column.
- `RPT_DLY`, 25_000_000: cycles a key must be held before auto-repeat starts.
- `RPT_PER`, 5_000_000: cycles between auto-repeat steps.

Ports:
- `clk`, in, 1: pixel/system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `SW`, in, 10: slide switches; `SW[NCH-1:0]` select the channel, `SW[9]` freezes `lvl`.
- `KEY`, in, 4: pushbuttons, active-low; [0] inc, [1] dec, [2] default selected channel, [3] default all channels.
- `row`, in, 13: current raster row.
- `col`, in, 13: current raster column.
- `frame_en`, out, 1: one-cycle frame-boundary strobe.
- `lvl`, out, NCH*LW: applied levels; channel i is `lvl[i*LW +: LW]`.
- `inc_p`, out, NCH: one-cycle per-channel increment step pulses.
- `dec_p`, out, NCH: one-cycle per-channel decrement step pulses.

## Operation
- **KEY synchronisation:** each KEY bit passes through a 2-FF synchroniser; the synchroniser resets to 1 (released). Press is detected on the synchronised 1→0 transition.
- **Selection:** valid only when exactly one of `SW[NCH-1:0]` is high. With zero or more than one bit high, no channel is selected and KEY[0..2] do nothing.
- **Working registers:** `pend[i]` hold the per-channel working levels. Shadow registers `lvl[i]` drive the output.
- **Inc/dec state machine** (states IDLE, HOLD, RPT):
  - IDLE: a press of exactly one of KEY[0]/KEY[1] with a valid selection → one step event; go to HOLD and clear the counter.
  - HOLD: counter reaching RPT_DLY-1 → step event; go to RPT and clear the counter.
  - RPT: counter reaching RPT_PER-1 → step event; clear the counter.
  - Release of the active key → IDLE.
  - Both KEY[0] and KEY[1] low → IDLE, no events, until both are released.
  - A selection change (synchronised SW bits differ from the value latched at entry to HOLD) → go to a WAIT state with no events until the key is released.
- **Step arithmetic:** computed at LW+1 bits and saturating.
  - Increment: if pend+STEP > 2^LW-1, the result is 2^LW-1.
  - Decrement: if pend < STEP, the result is 0.
  - A step at a limit still pulses `inc_p`/`dec_p`; the level stays unchanged.
- **Defaults:** a KEY[2] press loads `pend[sel]` with LVL_RST. A KEY[3] press loads every `pend` with LVL_RST, regardless of selection.
- **Priority within a cycle:** KEY[3] > KEY[2] > step event.
- **Frame apply:** `frame_en_c` = (row==ROW_MAX && col==COL_MAX).
  - On that edge, `lvl[i]` ← `pend[i]` for all i, unless `SW[9]`=1.
  - With `SW[9]`=1, `lvl` holds while `pend` continues to adjust.
  - `frame_en` still pulses while frozen.

## Timing
- **Reset values:** `frame_en`=0, `inc_p`=0, `dec_p`=0, all `pend` and all `lvl` = LVL_RST, FSM = IDLE, counter = 0.
- **Reset mid-hold:** the FSM returns to IDLE; a key still held after reset needs no re-press, because the synchroniser resets to released and sees a fresh 1→0 transition.
- **frame_en:** registered; high exactly one cycle, at the edge after `row`/`col` equal the boundary. `lvl` updates on the same edge that `frame_en` rises.
- **Key latency:** KEY sampled low at edge E0 → synchroniser at E0/E1 → `pend` update and `inc_p`/`dec_p` high at E2, for one cycle.
- **Repeat spacing:**
  - The first repeat step comes RPT_DLY cycles after the press step.
  - Each later step comes RPT_PER cycles after the previous one.
- **Step and frame boundary on the same edge:** `lvl` receives the pre-step `pend`; the step appears at the next frame.
- **KEY[3]/KEY[2] and frame boundary on the same edge:** `lvl` receives the pre-default values.

## Test plan
Settings: NCH=4, LW=8, STEP=4, LVL_RST=128, RPT_DLY=10, RPT_PER=4, ROW_MAX=2, COL_MAX=3.
1. Reset, SW=0x002, single press of KEY[0] held for 3 cycles:
   - `inc_p`=0x2 for one cycle, 3 edges after KEY falls.
   - `pend[1]`=132.
   - `lvl[1]` stays 128 until row=2/col=3, then becomes 132 together with `frame_en`.
2. SW=0x001, KEY[1] held for 30 cycles: `dec_p[0]` pulses at relative cycles 0, 10, 14, 18, 22, 26, giving `pend[0]`=104.
3. Saturation, SW=0x004:
   - 40 presses of KEY[0] → `pend[2]`=255, with a pulse on every press.
   - Then 70 presses of KEY[1] → 0, never wrapping.
4. Hazards:
   - SW=0x003 with KEY[0] pressed → no pulses, `pend` unchanged.
   - SW=0x001 with KEY[0] and KEY[1] both held → no pulses.
   - SW changes 0x001→0x002 during HOLD → no further pulses until KEY[0] is released and re-pressed.
5. Freeze and defaults:
   - SW[9]=1, adjust channel 0 to 140, run two frames → `lvl[0]` stays 128 and `frame_en` pulses twice.
   - SW[9]=0 → 140 at the next frame.
   - KEY[3] press → all `pend`=128; `lvl`=128 at the next frame.
6. Same-edge collision and reset:
   - Step event on the frame-boundary edge → `lvl` gets the old value, then the new value one frame later.
   - `rst` asserted mid-repeat → all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/adj_control.sv
// adj_control: front-panel level adjustment with saturating steps, auto-repeat
// while a key is held, and frame-synchronous transfer of working levels to lvl.
module adj_control #(
    parameter int NCH     = 4,
    parameter int LW      = 8,
    parameter int STEP    = 4,
    parameter int LVL_RST = 128,
    parameter int ROW_MAX = 480,
    parameter int COL_MAX = 640,
    parameter int RPT_DLY = 25_000_000,
    parameter int RPT_PER = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        SW,
    input  logic [3:0]        KEY,
    input  logic [12:0]       row,
    input  logic [12:0]       col,
    output logic              frame_en,
    output logic [NCH*LW-1:0] lvl,
    output logic [NCH-1:0]    inc_p,
    output logic [NCH-1:0]    dec_p
);
    localparam int CMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [LW:0]   STEP_X  = (LW+1)'(STEP);
    localparam logic [LW:0]   LVL_MAX = {1'b0, {LW{1'b1}}};
    localparam logic [LW-1:0] RST_V   = LW'(LVL_RST);
    localparam logic [CW-1:0] DLY_LIM = CW'(RPT_DLY - 1);
    localparam logic [CW-1:0] PER_LIM = CW'(RPT_PER - 1);

    typedef enum logic [1:0] {IDLE, HOLD, RPT, WAIT} state_t;

    // Synchronisers: only the switch bits actually used are brought across.
    logic [3:0]   key_m_q, key_m_d, key_s_q, key_s_d, key_p_q, key_p_d;
    logic [NCH:0] sw_m_q, sw_m_d, sw_s_q, sw_s_d;

    always_comb begin
        key_m_d = KEY;
        key_s_d = key_m_q;
        key_p_d = key_s_q;
        sw_m_d  = {SW[9], SW[NCH-1:0]};
        sw_s_d  = sw_m_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_m_q <= '1;
            key_s_q <= '1;
            key_p_q <= '1;
            sw_m_q  <= '0;
            sw_s_q  <= '0;
        end else begin
            key_m_q <= key_m_d;
            key_s_q <= key_s_d;
            key_p_q <= key_p_d;
            sw_m_q  <= sw_m_d;
            sw_s_q  <= sw_s_d;
        end
    end

    logic [1:0]     key_dn;
    logic [3:0]     key_fall;
    logic [NCH-1:0] sel;
    logic           sel_ok, freeze, inc_press, dec_press, both_dn;

    assign key_dn    = ~key_s_q[1:0];
    assign key_fall  = ~key_s_q & key_p_q;
    assign sel       = sw_s_q[NCH-1:0];
    assign sel_ok    = $onehot(sel);
    assign freeze    = sw_s_q[NCH];
    assign inc_press = key_fall[0] & ~key_dn[1];
    assign dec_press = key_fall[1] & ~key_dn[0];
    assign both_dn   = key_dn[0] & key_dn[1];

    // Inc/dec FSM
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, lim;
    logic           dir_q, dir_d;
    logic [NCH-1:0] sel_lat_q, sel_lat_d;
    logic           act_dn, sel_chg, cnt_hit;

    assign act_dn  = dir_q ? key_dn[0] : key_dn[1];
    assign sel_chg = (sel != sel_lat_q);
    assign lim     = (state_q == HOLD) ? DLY_LIM : PER_LIM;
    assign cnt_hit = (cnt_q == lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            sel_lat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            sel_lat_q <= sel_lat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        sel_lat_d = sel_lat_q;
        case (state_q)
            IDLE: begin
                if (sel_ok && (inc_press || dec_press)) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    dir_d     = inc_press;
                    sel_lat_d = sel;
                end
            end
            HOLD, RPT: begin
                // Release and key chords take precedence over a due repeat step.
                if (!act_dn || both_dn) begin
                    state_d = IDLE;
                end else if (sel_chg) begin
                    state_d = WAIT;
                end else if (cnt_hit) begin
                    state_d = RPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                if (!act_dn || both_dn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic           step, step_inc;
    logic [NCH-1:0] step_sel;

    always_comb begin
        step     = 1'b0;
        step_inc = dir_q;
        step_sel = sel_lat_q;
        case (state_q)
            IDLE: begin
                step     = sel_ok && (inc_press || dec_press);
                step_inc = inc_press;
                step_sel = sel;
            end
            HOLD, RPT: step = act_dn && !both_dn && !sel_chg && cnt_hit;
            default: step = 1'b0;
        endcase
    end

    // Level datapath
    logic [LW-1:0]  pend_q [NCH];
    logic [LW-1:0]  pend_d [NCH];
    logic [LW-1:0]  lvl_q  [NCH];
    logic [LW-1:0]  lvl_d  [NCH];
    logic [NCH-1:0] inc_p_q, inc_p_d, dec_p_q, dec_p_d;
    logic           frame_en_q, frame_en_d, frame_en_c;
    logic           def_all, def_sel;
    logic [LW:0]    up, dn;

    assign frame_en_c = (row == 13'(ROW_MAX)) && (col == 13'(COL_MAX));
    assign def_all    = key_fall[3];
    assign def_sel    = key_fall[2] & sel_ok;

    always_comb begin
        frame_en_d = frame_en_c;
        inc_p_d    = '0;
        dec_p_d    = '0;
        up         = '0;
        dn         = '0;
        for (int i = 0; i < NCH; i++) begin
            up        = {1'b0, pend_q[i]} + STEP_X;
            dn        = {1'b0, pend_q[i]} - STEP_X;
            pend_d[i] = pend_q[i];
            lvl_d[i]  = (frame_en_c && !freeze) ? pend_q[i] : lvl_q[i];
            if (def_all || (def_sel && sel[i])) begin
                pend_d[i] = RST_V;
            end else if (step && step_sel[i]) begin
                if (step_inc) begin
                    pend_d[i]  = (up > LVL_MAX) ? {LW{1'b1}} : up[LW-1:0];
                    inc_p_d[i] = 1'b1;
                end else begin
                    pend_d[i]  = ({1'b0, pend_q[i]} < STEP_X) ? '0 : dn[LW-1:0];
                    dec_p_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_en_q <= 1'b0;
            inc_p_q    <= '0;
            dec_p_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= RST_V;
                lvl_q[i]  <= RST_V;
            end
        end else begin
            frame_en_q <= frame_en_d;
            inc_p_q    <= inc_p_d;
            dec_p_q    <= dec_p_d;
            for (int i = 0; i < NCH; i++) begin
                pend_q[i] <= pend_d[i];
                lvl_q[i]  <= lvl_d[i];
            end
        end
    end

    assign frame_en = frame_en_q;
    assign inc_p    = inc_p_q;
    assign dec_p    = dec_p_q;

    for (genvar g = 0; g < NCH; g++) begin : g_lvl
        assign lvl[g*LW +: LW] = lvl_q[g];
    end

endmodule

// File: tb/tb_adj_control.sv
// Directed bench for adj_control with a short raster and short repeat timing.
module tb_adj_control;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [12:0] row, col;
    logic        frame_en;
    logic [31:0] lvl;
    logic [3:0]  inc_p, dec_p;

    int total = 0;
    int bad   = 0;

    adj_control #(
        .NCH(4), .LW(8), .STEP(4), .LVL_RST(128),
        .ROW_MAX(2), .COL_MAX(3), .RPT_DLY(10), .RPT_PER(4)
    ) dut (
        .clk(clk), .rst(rst), .SW(SW), .KEY(KEY), .row(row), .col(col),
        .frame_en(frame_en), .lvl(lvl), .inc_p(inc_p), .dec_p(dec_p)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] lv(input int i);
        return lvl[i*8 +: 8];
    endfunction

    // Press a key for 3 cycles, release for 4; counts step pulses seen.
    task automatic press_one(input logic [3:0] k, output int np);
        np = 0;
        KEY = k;
        repeat (3) begin
            tick(1);
            np += $countones(inc_p) + $countones(dec_p);
        end
        KEY = 4'hF;
        repeat (4) begin
            tick(1);
            np += $countones(inc_p) + $countones(dec_p);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; SW = '0; KEY = 4'hF; row = '0; col = '0;
        tick(2);
        rst = 1'b0;
        total++;
        if (frame_en !== 1'b0 || inc_p !== 4'h0 || dec_p !== 4'h0) begin
            bad++; $display("FAIL reset_strobes fe=%b inc=%b dec=%b want 0", frame_en, inc_p, dec_p);
        end
        total++;
        if (lvl !== 32'h80808080) begin
            bad++; $display("FAIL reset_lvl got=%h want=80808080", lvl);
        end
    endtask

    task automatic test_single_press;
        SW = 10'h002; tick(3);
        KEY = 4'b1110;
        tick(2);
        total++;
        if (inc_p !== 4'h0) begin bad++; $display("FAIL press_early inc=%b want 0000", inc_p); end
        tick(1);
        total++;
        if (inc_p !== 4'b0010 || dut.pend_q[1] !== 8'd132) begin
            bad++; $display("FAIL press_step inc=%b pend1=%0d want 0010/132", inc_p, dut.pend_q[1]);
        end
        KEY = 4'hF;
        tick(1);
        total++;
        if (inc_p !== 4'h0) begin bad++; $display("FAIL press_once inc=%b want 0000", inc_p); end
        tick(4);
        total++;
        if (lv(1) !== 8'd128) begin bad++; $display("FAIL lvl_before_frame got=%0d want 128", lv(1)); end
        row = 13'd2; col = 13'd3;
        tick(1);
        total++;
        if (frame_en !== 1'b1 || lv(1) !== 8'd132) begin
            bad++; $display("FAIL frame_apply fe=%b lvl1=%0d want 1/132", frame_en, lv(1));
        end
        row = '0; col = '0;
        tick(1);
        total++;
        if (frame_en !== 1'b0) begin bad++; $display("FAIL frame_one_cycle fe=%b want 0", frame_en); end
    endtask

    task automatic test_repeat;
        logic [3:0] exp;
        int r;
        SW = 10'h001; tick(3);
        KEY = 4'b1101;
        for (int t = 1; t <= 36; t++) begin
            if (t == 31) KEY = 4'hF;
            tick(1);
            r = t - 3;
            exp = (r == 0 || r == 10 || r == 14 || r == 18 || r == 22 || r == 26) ? 4'b0001 : 4'b0000;
            total++;
            if (dec_p !== exp) begin
                bad++; $display("FAIL repeat_t%0d dec=%b want %b", t, dec_p, exp);
            end
        end
        total++;
        if (dut.pend_q[0] !== 8'd104) begin
            bad++; $display("FAIL repeat_level got=%0d want 104", dut.pend_q[0]);
        end
    endtask

    task automatic test_saturation;
        int np, exp;
        SW = 10'h004; tick(3);
        exp = 128;
        for (int n = 0; n < 40; n++) begin
            press_one(4'b1110, np);
            exp = (exp + 4 > 255) ? 255 : exp + 4;
            total++;
            if (dut.pend_q[2] !== 8'(exp) || np !== 1) begin
                bad++; $display("FAIL sat_inc_%0d pend2=%0d np=%0d want %0d/1", n, dut.pend_q[2], np, exp);
            end
        end
        for (int n = 0; n < 70; n++) begin
            press_one(4'b1101, np);
            exp = (exp < 4) ? 0 : exp - 4;
            total++;
            if (dut.pend_q[2] !== 8'(exp) || np !== 1) begin
                bad++; $display("FAIL sat_dec_%0d pend2=%0d np=%0d want %0d/1", n, dut.pend_q[2], np, exp);
            end
        end
    endtask

    task automatic test_hazards;
        int np;
        SW = 10'h003; tick(3);
        press_one(4'b1110, np);
        total++;
        if (np !== 0 || dut.pend_q[0] !== 8'd104 || dut.pend_q[1] !== 8'd132) begin
            bad++; $display("FAIL multi_sel np=%0d p0=%0d p1=%0d want 0/104/132", np, dut.pend_q[0], dut.pend_q[1]);
        end
        SW = 10'h001; tick(3);
        KEY = 4'b1100; np = 0;
        repeat (15) begin tick(1); np += $countones(inc_p) + $countones(dec_p); end
        KEY = 4'hF; tick(4);
        total++;
        if (np !== 0 || dut.pend_q[0] !== 8'd104) begin
            bad++; $display("FAIL both_keys np=%0d p0=%0d want 0/104", np, dut.pend_q[0]);
        end
        KEY = 4'b1110; np = 0;
        repeat (3) begin tick(1); np += $countones(inc_p); end
        total++;
        if (np !== 1 || dut.pend_q[0] !== 8'd108) begin
            bad++; $display("FAIL chg_first np=%0d p0=%0d want 1/108", np, dut.pend_q[0]);
        end
        SW = 10'h002; np = 0;
        repeat (20) begin tick(1); np += $countones(inc_p) + $countones(dec_p); end
        KEY = 4'hF; tick(4);
        total++;
        if (np !== 0) begin bad++; $display("FAIL sel_change np=%0d want 0", np); end
        press_one(4'b1110, np);
        total++;
        if (np !== 1 || dut.pend_q[1] !== 8'd136) begin
            bad++; $display("FAIL after_wait np=%0d p1=%0d want 1/136", np, dut.pend_q[1]);
        end
    endtask

    task automatic test_freeze_defaults;
        int np;
        SW = 10'h201; tick(3);
        for (int n = 0; n < 8; n++) press_one(4'b1110, np);
        total++;
        if (dut.pend_q[0] !== 8'd140) begin bad++; $display("FAIL frz_adjust p0=%0d want 140", dut.pend_q[0]); end
        for (int f = 0; f < 2; f++) begin
            row = 13'd2; col = 13'd3; tick(1);
            total++;
            if (frame_en !== 1'b1 || lv(0) !== 8'd128 || lv(1) !== 8'd132) begin
                bad++; $display("FAIL frozen_%0d fe=%b l0=%0d l1=%0d want 1/128/132", f, frame_en, lv(0), lv(1));
            end
            row = '0; col = '0; tick(3);
        end
        SW = 10'h001; tick(3);
        row = 13'd2; col = 13'd3; tick(1);
        row = '0; col = '0;
        total++;
        if (lvl !== 32'h80_00_88_8C) begin bad++; $display("FAIL unfreeze lvl=%h want 8000888c", lvl); end
        SW = 10'h004; tick(3);
        press_one(4'b1011, np);
        total++;
        if (np !== 0 || dut.pend_q[2] !== 8'd128 || dut.pend_q[0] !== 8'd140) begin
            bad++; $display("FAIL def_sel np=%0d p2=%0d p0=%0d want 0/128/140", np, dut.pend_q[2], dut.pend_q[0]);
        end
        press_one(4'b0111, np);
        total++;
        if (dut.pend_q[0] !== 8'd128 || dut.pend_q[1] !== 8'd128 || dut.pend_q[3] !== 8'd128 || lv(0) !== 8'd140) begin
            bad++; $display("FAIL def_all p0=%0d p1=%0d l0=%0d want 128/128/140", dut.pend_q[0], dut.pend_q[1], lv(0));
        end
        row = 13'd2; col = 13'd3; tick(1);
        row = '0; col = '0;
        total++;
        if (lvl !== 32'h80808080) begin bad++; $display("FAIL def_apply lvl=%h want 80808080", lvl); end
    endtask

    task automatic test_collision;
        SW = 10'h001; tick(3);
        KEY = 4'b1110; tick(2);
        row = 13'd2; col = 13'd3; tick(1);
        total++;
        if (frame_en !== 1'b1 || inc_p !== 4'b0001 || lv(0) !== 8'd128 || dut.pend_q[0] !== 8'd132) begin
            bad++; $display("FAIL collide fe=%b inc=%b l0=%0d p0=%0d want 1/0001/128/132", frame_en, inc_p, lv(0), dut.pend_q[0]);
        end
        row = '0; col = '0; KEY = 4'hF; tick(4);
        row = 13'd2; col = 13'd3; tick(1);
        row = '0; col = '0;
        total++;
        if (lv(0) !== 8'd132) begin bad++; $display("FAIL collide_next l0=%0d want 132", lv(0)); end
    endtask

    task automatic test_reset_mid;
        KEY = 4'b1110; tick(15);
        rst = 1'b1; row = 13'd2; col = 13'd3;
        tick(1);
        total++;
        if (frame_en !== 1'b0 || inc_p !== 4'h0 || dec_p !== 4'h0 || lvl !== 32'h80808080 || dut.pend_q[0] !== 8'd128) begin
            bad++; $display("FAIL reset_mid fe=%b inc=%b lvl=%h p0=%0d want 0/0000/80808080/128", frame_en, inc_p, lvl, dut.pend_q[0]);
        end
        rst = 1'b0; row = '0; col = '0;
        tick(2);
        total++;
        if (inc_p !== 4'h0) begin bad++; $display("FAIL rearm_early inc=%b want 0000", inc_p); end
        tick(1);
        total++;
        if (inc_p !== 4'b0001 || dut.pend_q[0] !== 8'd132) begin
            bad++; $display("FAIL rearm inc=%b p0=%0d want 0001/132", inc_p, dut.pend_q[0]);
        end
        KEY = 4'hF; tick(4);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_repeat();
        test_saturation();
        test_hazards();
        test_freeze_defaults();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
